// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: RV funct3 opcodes and FSM state encoding.
package alu_pkg;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU for all RV funct3 ops (barrel shifter for shifts).
// Ports:
//   i_a, i_b   operands (shifts use i_b[SHAMT_W-1:0] only)
//   i_func     funct3
//   i_f7_bit   funct7[5]: SUB / SRA select
//   i_is_imm   immediate form: funct3 000 is always ADD
//   o_y        result
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_func,
    input  logic             i_f7_bit,
    input  logic             i_is_imm,
    output logic [WIDTH-1:0] o_y
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    logic [SHAMT_W-1:0] w_shamt;
    logic               w_slt;
    logic               w_sltu;

    assign w_shamt = i_b[SHAMT_W-1:0];
    assign w_slt   = $signed(i_a) < $signed(i_b);
    assign w_sltu  = i_a < i_b;

    // Operation select
    always_comb begin
        o_y = '0;
        case (i_func)
            F3_ADD_SUB: o_y = (i_f7_bit && !i_is_imm) ? (i_a - i_b) : (i_a + i_b);
            F3_SLL:     o_y = i_a << w_shamt;
            F3_SLT:     o_y = {{(WIDTH-1){1'b0}}, w_slt};
            F3_SLTU:    o_y = {{(WIDTH-1){1'b0}}, w_sltu};
            F3_XOR:     o_y = i_a ^ i_b;
            F3_SRL_SRA: o_y = i_f7_bit ? WIDTH'($signed(i_a) >>> w_shamt) : (i_a >> w_shamt);
            F3_OR:      o_y = i_a | i_b;
            F3_AND:     o_y = i_a & i_b;
            default:    o_y = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU wrapper: valid/ready handshake, optional bit-serial shifter, result hold.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid / in_ready     request handshake (in_ready only in IDLE)
//   value1, value2          operands
//   func_type, f7_bit,      RV funct3, funct7[5], immediate form
//   is_imm
//   out_valid / out_ready   result handshake
//   result                  registered result
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned SERIAL_SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] value1,
    input  logic [WIDTH-1:0] value2,
    input  logic [2:0]       func_type,
    input  logic             f7_bit,
    input  logic             is_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_result;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_right;
    logic               r_arith;

    logic [WIDTH-1:0]   w_core_y;
    logic [WIDTH-1:0]   w_work_nxt;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_is_shift;
    logic               w_serial_go;
    logic               w_accept;
    logic               w_last;
    logic               w_in_ready;
    logic               w_out_valid;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_a      (value1),
        .i_b      (value2),
        .i_func   (func_type),
        .i_f7_bit (f7_bit),
        .i_is_imm (is_imm),
        .o_y      (w_core_y)
    );

    assign w_shamt     = value2[SHAMT_W-1:0];
    assign w_is_shift  = (func_type == F3_SLL) || (func_type == F3_SRL_SRA);
    // Zero-amount shifts take the single-cycle path even in serial mode
    assign w_serial_go = (SERIAL_SHIFT != 0) && w_is_shift && (w_shamt != '0);
    assign w_accept    = in_valid && w_in_ready;
    assign w_last      = (r_cnt == SHAMT_W'(1));

    // One-bit step of the working register; SRA refills with the held MSB
    always_comb begin
        w_work_nxt = r_work;
        if (r_right) begin
            w_work_nxt = {r_arith & r_work[WIDTH-1], r_work[WIDTH-1:1]};
        end else begin
            w_work_nxt = {r_work[WIDTH-2:0], 1'b0};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_serial_go ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: w_in_ready  = 1'b1;
            ST_DONE: w_out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture on accept, serial shifting, result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_right  <= 1'b0;
            r_arith  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_accept) begin
                r_right <= (func_type == F3_SRL_SRA);
                r_arith <= f7_bit;
                if (w_serial_go) begin
                    r_work <= value1;
                    r_cnt  <= w_shamt;
                end else begin
                    r_result <= w_core_y;
                end
            end else if (r_state == ST_SHIFT) begin
                r_work <= w_work_nxt;
                r_cnt  <= r_cnt - SHAMT_W'(1);
                if (w_last) begin
                    r_result <= w_work_nxt;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign result    = r_result;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width, power of two, 8..64.
REQ-002 Parameter SERIAL_SHIFT, default 1: 1 = shifts run one bit per cycle; 0 = shifts complete in one cycle via barrel shifter.
REQ-003 Derived constant SHAMT_W = log2(WIDTH): shift-amount width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 value1  input  WIDTH  operand A.
REQ-009 value2  input  WIDTH  operand B; shifts use value2[SHAMT_W-1:0] only.
REQ-010 func_type  input  3  RV funct3 (ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111).
REQ-011 f7_bit  input  1  funct7[5]: 1 selects SUB (funct3 000) or SRA (funct3 101).
REQ-012 is_imm  input  1  immediate-form op: f7_bit ignored for funct3 000 (always ADD).
REQ-013 out_valid  output  1  result holds a completed operation.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 result  output  WIDTH  operation result.

Function
REQ-016 A transfer in SHALL occur when in_valid && in_ready at a rising clk edge; operands, func_type, f7_bit, is_imm latched then.
REQ-017 FSM states: IDLE, SHIFT, DONE; in_ready SHALL equal (state == IDLE).
REQ-018 IDLE + transfer, non-shift op or shift with shamt 0 or SERIAL_SHIFT=0 -> DONE with result registered; out_valid high the next cycle (latency 1).
REQ-019 IDLE + transfer, shift op, SERIAL_SHIFT=1, shamt N>0 -> SHIFT with counter = N; each SHIFT cycle shifts working register one bit and decrements counter; at counter 1 -> DONE; out_valid first high N+1 cycles after transfer.
REQ-020 SLL fills 0 at LSB; SRL fills 0 at MSB; SRA replicates original MSB.
REQ-021 SLT result = 1 if signed(value1) < signed(value2), else 0; SLTU same unsigned; upper bits zero.
REQ-022 ADD/SUB wrap modulo 2^WIDTH; no carry/overflow output.
REQ-023 DONE: out_valid = 1, result stable; out_ready high at edge -> IDLE, out_valid falls next cycle.
REQ-024 Max throughput one op per 2 cycles; no accept in the cycle a result is consumed.
REQ-025 in_valid, operand and func_type changes while not in IDLE SHALL be ignored.
REQ-026 out_ready while out_valid low SHALL have no effect.
REQ-027 Shift amount value2[SHAMT_W-1:0] = WIDTH-1 is maximum; upper value2 bits never affect shifts.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, out_valid 0, result 0, counter 0, working register 0.
REQ-029 Reset during SHIFT or DONE SHALL discard the operation; no out_valid emitted after release.
REQ-030 First transfer possible at first rising edge after rst_n released; in_ready 1 from release.

Structure
REQ-031 Shared package alu_pkg SHALL hold funct3 localparams and FSM state encoding.
REQ-032 Single sub-module alu_core SHALL implement all single-cycle ops combinationally (parametrised WIDTH); alu_seq owns FSM, counter, shift register and handshake.

Verification
REQ-033 WIDTH=32: ADD 0xFFFFFFFF+1 -> result 0x00000000, out_valid one cycle after transfer.
REQ-034 SUB f7=1 5-7 -> 0xFFFFFFFE; same with is_imm=1 -> ADD, 0x0000000C.
REQ-035 SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
REQ-036 SERIAL_SHIFT=1 SRA 0x80000000 by 4 -> 0xF8000000, out_valid 5 cycles after transfer; SRL -> 0x08000000; shamt 0 -> operand, latency 1.
REQ-037 Hold out_ready low 3 cycles in DONE -> result/out_valid stable, in_ready 0, new in_valid ignored; then accept.
REQ-038 Assert rst_n low mid-SHIFT (SLL by 20) -> out_valid 0, in_ready 1 after release, no stale result.
